// File: rtl/clock_div_ctrl.sv
// Runtime-programmable 50%-duty clock divider with a valid/ready ratio port.
// Ratio changes and stops are deferred to period boundaries so clkout never glitches.
module clock_div_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run_en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clkout,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic         pend_valid_q, pend_valid_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         cfg_err_q, cfg_err_d;
  logic         tick_q, tick_d;
  logic         pos_hi_q, pos_hi_d;
  logic         neg_hi_q;
  logic         accept;
  logic         boundary;

  // ceil(d/2) without needing a W+1-bit intermediate, so d = 2^W-1 is safe.
  function automatic logic [W-1:0] half_up(input logic [W-1:0] d);
    return (d >> 1) + {{(W-1){1'b0}}, d[0]};
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    cfg_err_d    = 1'b0;
    tick_d       = 1'b0;
    accept       = cfg_valid & ~pend_valid_q;
    boundary     = (state_q == RUN) && (cnt_q == cur_div_q - W'(1));

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          cur_div_d    = pend_div_q;
          pend_valid_d = 1'b0;
        end
        if (run_en) begin
          state_d = RUN;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            cur_div_d    = pend_div_q;
            pend_valid_d = 1'b0;
          end
          if (run_en) tick_d  = 1'b1;
          else        state_d = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept only happens with the slot empty, so it never collides with an apply above.
    if (accept) begin
      if (cfg_div < W'(2)) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_div_d   = cfg_div;
      end
    end

    pos_hi_d = (state_d == RUN) && (cnt_d < half_up(cur_div_d));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_div_q    <= W'(DEF_DIV);
      pend_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      tick_q       <= 1'b0;
      pos_hi_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_valid_q <= pend_valid_d;
      cfg_err_q    <= cfg_err_d;
      tick_q       <= tick_d;
      pos_hi_q     <= pos_hi_d;
    end
  end

  // NOTE: pend_div_q is a data register qualified by pend_valid_q, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    pend_div_q <= pend_div_d;
  end

  // Half-cycle delayed copy of pos_hi; ANDed in for odd ratios to trim half a cycle.
  always_ff @(negedge clk) begin
    if (rst) neg_hi_q <= 1'b0;
    else     neg_hi_q <= pos_hi_q;
  end

  assign clkout    = cur_div_q[0] ? (pos_hi_q & neg_hi_q) : pos_hi_q;
  assign tick      = tick_q;
  assign busy      = (state_q == RUN);
  assign cur_div   = cur_div_q;
  assign cfg_ready = ~pend_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl: directed scenarios then random traffic,
// compared against a period/phase model that predicts clkout per half-cycle.
module tb_clock_div_ctrl;
  localparam int W       = 8;
  localparam int DEF_DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         run_en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clkout;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  always #5 clk = ~clk;

  clock_div_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clkout    (clkout),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: whether a period is in progress, which cycle of it we are in, and its length.
  bit m_run;
  int m_k;
  int m_div;
  bit m_pend_v;
  int m_pend;
  bit m_err;
  bit m_tick;

  bit last_h;
  bit last_l;

  // Output level at half-cycle t of a D-cycle period (t=0 is the half after the period's first posedge).
  // Even D: high for the first D halves. Odd D: high for D halves starting at the first falling edge.
  function automatic bit hi_at(input int t, input int d);
    if (d % 2 == 0) return (t < d);
    return (t >= 1) && (t <= d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int cd;
    cd = int'(cfg_div);
    if (rst) begin
      m_run = 0; m_k = 0; m_div = DEF_DIV; m_pend_v = 0; m_err = 0; m_tick = 0;
      return;
    end
    acc    = cfg_valid && !m_pend_v;
    m_tick = 0;
    if (m_run) begin
      if (m_k == m_div - 1) begin
        if (m_pend_v) begin m_div = m_pend; m_pend_v = 0; end
        m_k = 0;
        if (run_en) m_tick = 1;
        else        m_run  = 0;
      end else begin
        m_k++;
      end
    end else begin
      if (m_pend_v) begin m_div = m_pend; m_pend_v = 0; end
      if (run_en) begin m_run = 1; m_k = 0; m_tick = 1; end
    end
    m_err = acc && (cd < 2);
    if (acc && cd >= 2) begin m_pend_v = 1; m_pend = cd; end
  endtask

  task automatic step(input bit r, input bit cv, input int cd);
    run_en    = r;
    cfg_valid = cv;
    cfg_div   = cd[W-1:0];
    @(posedge clk);
    model_edge();
    #1;
    check("busy",      busy,      m_run);
    check("tick",      tick,      m_tick);
    check("cur_div",   cur_div,   m_div);
    check("cfg_ready", cfg_ready, !m_pend_v);
    check("cfg_err",   cfg_err,   m_err);
    check("clkout_h",  clkout,    m_run ? hi_at(2*m_k, m_div) : 1'b0);
    last_h = clkout;
    @(negedge clk);
    #1;
    check("clkout_l",  clkout,    m_run ? hi_at(2*m_k+1, m_div) : 1'b0);
    last_l = clkout;
  endtask

  // Run until the model reaches cycle k of a period with ratio d; bounded.
  task automatic run_until(input int d, input int k, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      step(1, 0, 0);
      if (m_run && m_div == d && m_k == k) begin found = 1; break; end
    end
    check("run_until_timeout", found, 1);
  endtask

  initial begin
    int hi_halves;
    bit got_tick;
    int pick;

    rst = 1; run_en = 0; cfg_valid = 0; cfg_div = '0;
    m_run = 0; m_k = 0; m_div = DEF_DIV; m_pend_v = 0; m_pend = 0; m_err = 0; m_tick = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 0;
    step(0, 0, 0);

    // Default ratio 4.
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Ratio 5 with measured duty over one full period.
    step(1, 1, 5);
    run_until(5, 4, 20);
    got_tick = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      if (tick) begin got_tick = 1; break; end
    end
    check("tick5_timeout", got_tick, 1);
    hi_halves = int'(last_h) + int'(last_l);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      hi_halves += int'(last_h) + int'(last_l);
    end
    check("duty5_half_cycles", hi_halves, 5);

    // Back to 4, then write 6 at cnt=1: current period stays 4.
    step(1, 1, 4);
    run_until(4, 1, 30);
    step(1, 1, 6);
    for (int i = 0; i < 16; i++) step(1, 0, 0);

    // Illegal ratio 1.
    step(1, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);

    // Stop at cnt=1 with ratio 8, plus a dip of run_en inside a period.
    step(1, 1, 8);
    run_until(8, 1, 40);
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // Reset in the high phase with ratio 6 running and 3 pending.
    step(1, 1, 6);
    run_until(6, 1, 40);
    step(1, 1, 3);
    rst = 1;
    step(1, 0, 0);
    rst = 0;
    check("post_rst_cur_div", cur_div, DEF_DIV);
    check("post_rst_ready", cfg_ready, 1);
    step(0, 0, 0);
    step(0, 0, 0);

    // Extremes: ratio 2 and the maximum ratio.
    step(0, 1, 2);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, (1 << W) - 1);
    for (int i = 0; i < 2 * ((1 << W) - 1) + 4; i++) step(1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom % 200) == 0;
      pick = int'($urandom % 10);
      step(($urandom % 8) != 0, ($urandom % 3) == 0,
           (pick == 0) ? 0 : (pick == 1) ? 1 : 2 + int'($urandom % 10));
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
